// File: rtl/dandriscv_mem_pkg.sv
// Shared types and constants for the icache/dcache memory port arbiter.
package dandriscv_mem_pkg;

   typedef enum logic {OWN_ICACHE = 1'b0, OWN_DCACHE = 1'b1} mem_owner_e;
   typedef enum logic {ARB_IDLE = 1'b0, ARB_WAIT_RSP = 1'b1} arb_state_e;

   localparam logic [2:0] ISIZE_WORD = 3'd2;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational owner pick for the shared memory port.
// MEM_ARB_RR_EN: round-robin on contention; otherwise dcache has fixed priority.
module mem_arb_grant
   import dandriscv_mem_pkg::*;
(
   input  logic ivalid,
   input  logic dvalid,
   input  logic lock,
   input  logic locked_owner,
`ifdef MEM_ARB_RR_EN
   input  logic last_grant,
`endif
   output logic owner
);

   always_comb begin
      owner = OWN_ICACHE;
      if (lock) begin
         owner = locked_owner;
      end else if (ivalid && dvalid) begin
`ifdef MEM_ARB_RR_EN
         owner = ~last_grant;
`else
         owner = OWN_DCACHE;
`endif
      end else if (dvalid) begin
         owner = OWN_DCACHE;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache and dcache, one transaction in flight.
// Optional MEM_ARB_RR_EN enables round-robin arbitration (see mem_arb_grant).
module mem_port_arbiter
   import dandriscv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned INSTR_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  icache_cmd_valid,
   output logic                  icache_cmd_ready,
   input  logic [ADDR_W-1:0]     icache_cmd_payload_addr,
   output logic                  icache_rsp_valid,
   output logic [INSTR_W-1:0]    icache_rsp_payload_data,
   input  logic                  dcache_cmd_valid,
   output logic                  dcache_cmd_ready,
   input  logic [ADDR_W-1:0]     dcache_cmd_payload_addr,
   input  logic                  dcache_cmd_payload_wen,
   input  logic [DATA_W-1:0]     dcache_cmd_payload_wdata,
   input  logic [DATA_W/8-1:0]   dcache_cmd_payload_wstrb,
   input  logic [2:0]            dcache_cmd_payload_size,
   output logic                  dcache_rsp_valid,
   output logic [DATA_W-1:0]     dcache_rsp_payload_data,
   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic [ADDR_W-1:0]     mem_cmd_payload_addr,
   output logic                  mem_cmd_payload_wen,
   output logic [DATA_W-1:0]     mem_cmd_payload_wdata,
   output logic [DATA_W/8-1:0]   mem_cmd_payload_wstrb,
   output logic [2:0]            mem_cmd_payload_size,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_W-1:0]     mem_rsp_payload_data,
   output logic                  stray_rsp
);

   arb_state_e state_q, state_d;
   mem_owner_e owner_q, owner_d;
   mem_owner_e locked_owner_q, locked_owner_d;
   mem_owner_e grant;
   logic       lock_q, lock_d;
   logic       ihalf_q, ihalf_d;
   logic       grant_raw;
   logic       cmd_valid;
`ifdef MEM_ARB_RR_EN
   mem_owner_e last_grant_q, last_grant_d;
`endif

   mem_arb_grant u_grant (
      .ivalid       (icache_cmd_valid),
      .dvalid       (dcache_cmd_valid),
      .lock         (lock_q),
      .locked_owner (locked_owner_q),
`ifdef MEM_ARB_RR_EN
      .last_grant   (last_grant_q),
`endif
      .owner        (grant_raw)
   );

   assign grant     = mem_owner_e'(grant_raw);
   assign cmd_valid = (grant == OWN_DCACHE) ? dcache_cmd_valid : icache_cmd_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ARB_IDLE;
         lock_q         <= 1'b0;
         locked_owner_q <= OWN_ICACHE;
         owner_q        <= OWN_ICACHE;
         ihalf_q        <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_grant_q   <= OWN_ICACHE;
`endif
      end else begin
         state_q        <= state_d;
         lock_q         <= lock_d;
         locked_owner_q <= locked_owner_d;
         owner_q        <= owner_d;
         ihalf_q        <= ihalf_d;
`ifdef MEM_ARB_RR_EN
         last_grant_q   <= last_grant_d;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      lock_d         = lock_q;
      locked_owner_d = locked_owner_q;
      owner_d        = owner_q;
      ihalf_d        = ihalf_q;
`ifdef MEM_ARB_RR_EN
      last_grant_d   = last_grant_q;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            if (cmd_valid) begin
               if (mem_cmd_ready) begin
                  owner_d = grant;
                  ihalf_d = icache_cmd_payload_addr[2];
                  lock_d  = 1'b0;
                  state_d = ARB_WAIT_RSP;
               end else begin
                  // Freeze the grant while the memory stalls so the payload stays stable.
                  lock_d         = 1'b1;
                  locked_owner_d = grant;
               end
            end
         end
         ARB_WAIT_RSP: begin
            if (mem_rsp_valid) begin
`ifdef MEM_ARB_RR_EN
               last_grant_d = owner_q;
`endif
               state_d = ARB_IDLE;
            end
         end
      endcase
   end

   // Outputs are held quiet during reset so a response in flight is dropped at once.
   always_comb begin
      icache_cmd_ready        = 1'b0;
      dcache_cmd_ready        = 1'b0;
      icache_rsp_valid        = 1'b0;
      icache_rsp_payload_data = '0;
      dcache_rsp_valid        = 1'b0;
      dcache_rsp_payload_data = '0;
      mem_cmd_valid           = 1'b0;
      mem_cmd_payload_addr    = '0;
      mem_cmd_payload_wen     = 1'b0;
      mem_cmd_payload_wdata   = '0;
      mem_cmd_payload_wstrb   = '0;
      mem_cmd_payload_size    = '0;
      stray_rsp               = 1'b0;
      if (!reset) begin
         unique case (state_q)
            ARB_IDLE: begin
               stray_rsp     = mem_rsp_valid;
               mem_cmd_valid = cmd_valid;
               if (grant == OWN_DCACHE) begin
                  dcache_cmd_ready = mem_cmd_ready;
                  if (dcache_cmd_valid) begin
                     mem_cmd_payload_addr  = dcache_cmd_payload_addr;
                     mem_cmd_payload_wen   = dcache_cmd_payload_wen;
                     mem_cmd_payload_wdata = dcache_cmd_payload_wdata;
                     mem_cmd_payload_wstrb = dcache_cmd_payload_wstrb;
                     mem_cmd_payload_size  = dcache_cmd_payload_size;
                  end
               end else begin
                  icache_cmd_ready = mem_cmd_ready;
                  if (icache_cmd_valid) begin
                     mem_cmd_payload_addr = icache_cmd_payload_addr;
                     mem_cmd_payload_size = ISIZE_WORD;
                  end
               end
            end
            ARB_WAIT_RSP: begin
               if (mem_rsp_valid) begin
                  if (owner_q == OWN_DCACHE) begin
                     dcache_rsp_valid        = 1'b1;
                     dcache_rsp_payload_data = mem_rsp_payload_data;
                  end else begin
                     icache_rsp_valid        = 1'b1;
                     icache_rsp_payload_data = ihalf_q ? mem_rsp_payload_data[DATA_W-1:INSTR_W]
                                                       : mem_rsp_payload_data[INSTR_W-1:0];
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
   localparam int unsigned ADDR_W = 64, DATA_W = 64, INSTR_W = 32;

   logic clk = 1'b0;
   logic reset;
   logic icache_cmd_valid, icache_cmd_ready, icache_rsp_valid;
   logic [ADDR_W-1:0] icache_cmd_payload_addr;
   logic [INSTR_W-1:0] icache_rsp_payload_data;
   logic dcache_cmd_valid, dcache_cmd_ready, dcache_cmd_payload_wen, dcache_rsp_valid;
   logic [ADDR_W-1:0] dcache_cmd_payload_addr;
   logic [DATA_W-1:0] dcache_cmd_payload_wdata, dcache_rsp_payload_data;
   logic [DATA_W/8-1:0] dcache_cmd_payload_wstrb;
   logic [2:0] dcache_cmd_payload_size;
   logic mem_cmd_valid, mem_cmd_ready, mem_cmd_payload_wen, mem_rsp_valid, stray_rsp;
   logic [ADDR_W-1:0] mem_cmd_payload_addr;
   logic [DATA_W-1:0] mem_cmd_payload_wdata, mem_rsp_payload_data;
   logic [DATA_W/8-1:0] mem_cmd_payload_wstrb;
   logic [2:0] mem_cmd_payload_size;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) dut (
      .clk(clk), .reset(reset),
      .icache_cmd_valid(icache_cmd_valid), .icache_cmd_ready(icache_cmd_ready),
      .icache_cmd_payload_addr(icache_cmd_payload_addr),
      .icache_rsp_valid(icache_rsp_valid), .icache_rsp_payload_data(icache_rsp_payload_data),
      .dcache_cmd_valid(dcache_cmd_valid), .dcache_cmd_ready(dcache_cmd_ready),
      .dcache_cmd_payload_addr(dcache_cmd_payload_addr),
      .dcache_cmd_payload_wen(dcache_cmd_payload_wen),
      .dcache_cmd_payload_wdata(dcache_cmd_payload_wdata),
      .dcache_cmd_payload_wstrb(dcache_cmd_payload_wstrb),
      .dcache_cmd_payload_size(dcache_cmd_payload_size),
      .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_payload_data(dcache_rsp_payload_data),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_payload_addr(mem_cmd_payload_addr), .mem_cmd_payload_wen(mem_cmd_payload_wen),
      .mem_cmd_payload_wdata(mem_cmd_payload_wdata),
      .mem_cmd_payload_wstrb(mem_cmd_payload_wstrb),
      .mem_cmd_payload_size(mem_cmd_payload_size),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_payload_data(mem_rsp_payload_data),
      .stray_rsp(stray_rsp)
   );

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit m_last_d = 1'b0;  // model: requester served most recently was the dcache

   // Model of arbitration: 1 = dcache wins.
   function automatic bit pick(bit iv, bit dv);
      if (iv && dv) return RR ? !m_last_d : 1'b1;
      return dv;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_i(bit v, logic [ADDR_W-1:0] a);
      icache_cmd_valid = v;
      icache_cmd_payload_addr = a;
   endtask

   task automatic set_d(bit v, logic [ADDR_W-1:0] a, bit we, logic [DATA_W-1:0] wd,
                        logic [7:0] st, logic [2:0] sz);
      dcache_cmd_valid = v;
      dcache_cmd_payload_addr = a;
      dcache_cmd_payload_wen = we;
      dcache_cmd_payload_wdata = wd;
      dcache_cmd_payload_wstrb = st;
      dcache_cmd_payload_size = sz;
   endtask

   task automatic test_reset();
      set_i(0, '0); set_d(0, '0, 0, '0, '0, '0);
      mem_cmd_ready = 0; mem_rsp_valid = 0; mem_rsp_payload_data = '0;
      reset = 1;
      tick(); tick();
      reset = 0;
      @(negedge clk);
      n_checks++; if (mem_cmd_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset mem_cmd_valid: got %b want 0", mem_cmd_valid); end
      n_checks++; if ({icache_cmd_ready, dcache_cmd_ready} !== 2'b00) begin n_fail++;
         $display("FAIL reset cmd_ready: got %b want 00", {icache_cmd_ready, dcache_cmd_ready}); end
      n_checks++; if ({icache_rsp_valid, dcache_rsp_valid} !== 2'b00) begin n_fail++;
         $display("FAIL reset rsp_valid: got %b want 00", {icache_rsp_valid, dcache_rsp_valid}); end
      n_checks++; if (stray_rsp !== 1'b0) begin n_fail++;
         $display("FAIL reset stray_rsp: got %b want 0", stray_rsp); end
      n_checks++; if (mem_cmd_payload_addr !== '0 || mem_cmd_payload_wdata !== '0) begin n_fail++;
         $display("FAIL reset payload: got %h/%h want 0", mem_cmd_payload_addr,
                  mem_cmd_payload_wdata); end
      n_checks++; if (icache_rsp_payload_data !== '0 || dcache_rsp_payload_data !== '0) begin
         n_fail++; $display("FAIL reset rsp_data: got %h/%h want 0", icache_rsp_payload_data,
                            dcache_rsp_payload_data); end
      tick();
      m_last_d = 0;
   endtask

   // Single icache fetch; addr[2] picks which 32-bit half is returned.
   task automatic icache_fetch(string nm, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] rd,
                               logic [INSTR_W-1:0] want);
      set_i(1, a); mem_cmd_ready = 1;
      @(negedge clk);
      n_checks++; if (mem_cmd_valid !== 1'b1 || icache_cmd_ready !== 1'b1 ||
                      dcache_cmd_ready !== 1'b0) begin n_fail++;
         $display("FAIL %s grant: got v=%b ir=%b dr=%b want 1 1 0", nm, mem_cmd_valid,
                  icache_cmd_ready, dcache_cmd_ready); end
      n_checks++; if (mem_cmd_payload_addr !== a || mem_cmd_payload_wen !== 1'b0 ||
                      mem_cmd_payload_wstrb !== '0 || mem_cmd_payload_size !== 3'd2) begin
         n_fail++; $display("FAIL %s payload: got a=%h we=%b st=%h sz=%0d want a=%h 0 0 2", nm,
                            mem_cmd_payload_addr, mem_cmd_payload_wen, mem_cmd_payload_wstrb,
                            mem_cmd_payload_size, a); end
      tick();
      set_i(0, '0); mem_rsp_valid = 1; mem_rsp_payload_data = rd;
      @(negedge clk);
      n_checks++; if (icache_rsp_valid !== 1'b1 || dcache_rsp_valid !== 1'b0) begin n_fail++;
         $display("FAIL %s rsp_valid: got i=%b d=%b want 1 0", nm, icache_rsp_valid,
                  dcache_rsp_valid); end
      n_checks++; if (icache_rsp_payload_data !== want) begin n_fail++;
         $display("FAIL %s rsp_data: got %h want %h", nm, icache_rsp_payload_data, want); end
      tick();
      mem_rsp_valid = 0; m_last_d = 0;
      @(negedge clk);
      n_checks++; if (icache_rsp_valid !== 1'b0) begin n_fail++;
         $display("FAIL %s rsp_pulse: got %b want 0", nm, icache_rsp_valid); end
      tick();
   endtask

   task automatic test_icache_only();
      icache_fetch("icache_only", 64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);
   endtask

   task automatic test_low_half();
      icache_fetch("low_half", 64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 32'hCCCC_DDDD);
   endtask

   task automatic test_priority();
      set_i(1, 64'h8000_0008); set_d(1, 64'h8000_0100, 0, '0, '0, 3'd3); mem_cmd_ready = 1;
      @(negedge clk);
      n_checks++; if (mem_cmd_payload_addr !== 64'h8000_0100 || dcache_cmd_ready !== 1'b1 ||
                      icache_cmd_ready !== 1'b0) begin n_fail++;
         $display("FAIL priority grant: got a=%h ir=%b dr=%b want 80000100 0 1",
                  mem_cmd_payload_addr, icache_cmd_ready, dcache_cmd_ready); end
      tick();
      set_d(0, '0, 0, '0, '0, '0); mem_rsp_valid = 1; mem_rsp_payload_data = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      n_checks++; if (dcache_rsp_valid !== 1'b1 || icache_rsp_valid !== 1'b0 ||
                      dcache_rsp_payload_data !== 64'h0123_4567_89AB_CDEF) begin n_fail++;
         $display("FAIL priority drsp: got v=%b iv=%b d=%h", dcache_rsp_valid, icache_rsp_valid,
                  dcache_rsp_payload_data); end
      n_checks++; if (mem_cmd_valid !== 1'b0 || icache_cmd_ready !== 1'b0) begin n_fail++;
         $display("FAIL priority rsp_cycle_accept: got v=%b ir=%b want 0 0", mem_cmd_valid,
                  icache_cmd_ready); end
      tick();
      mem_rsp_valid = 0; m_last_d = 1;
      @(negedge clk);
      n_checks++; if (icache_cmd_ready !== 1'b1 || mem_cmd_payload_addr !== 64'h8000_0008) begin
         n_fail++; $display("FAIL priority second_grant: got ir=%b a=%h want 1 80000008",
                            icache_cmd_ready, mem_cmd_payload_addr); end
      tick();
      set_i(0, '0); mem_rsp_valid = 1; mem_rsp_payload_data = 64'h7777_6666_5555_4444;
      @(negedge clk);
      n_checks++; if (icache_rsp_valid !== 1'b1 || icache_rsp_payload_data !== 32'h5555_4444) begin
         n_fail++; $display("FAIL priority irsp: got v=%b d=%h want 1 55554444",
                            icache_rsp_valid, icache_rsp_payload_data); end
      tick();
      mem_rsp_valid = 0; m_last_d = 0;
   endtask

   // Both requesters valid for four back-to-back transactions.
   task automatic test_both_valid();
      bit win;
      mem_cmd_ready = 1;
      for (int k = 0; k < 4; k++) begin
         set_i(1, 64'h1000 + 64'(k * 8)); set_d(1, 64'h2000 + 64'(k * 8), 0, '0, '0, 3'd3);
         win = pick(1, 1);
         @(negedge clk);
         n_checks++; if (dcache_cmd_ready !== win || icache_cmd_ready !== !win ||
                         mem_cmd_payload_addr !== (win ? 64'h2000 : 64'h1000) + 64'(k * 8)) begin
            n_fail++; $display("FAIL both_valid grant %0d: got dr=%b ir=%b a=%h want dcache=%b",
                               k, dcache_cmd_ready, icache_cmd_ready, mem_cmd_payload_addr, win);
         end
         tick();
         mem_rsp_valid = 1; mem_rsp_payload_data = {$urandom, $urandom};
         @(negedge clk);
         n_checks++; if (dcache_rsp_valid !== win || icache_rsp_valid !== !win) begin n_fail++;
            $display("FAIL both_valid rsp %0d: got d=%b i=%b want dcache=%b", k,
                     dcache_rsp_valid, icache_rsp_valid, win); end
         tick();
         mem_rsp_valid = 0; m_last_d = win;
      end
      set_i(0, '0); set_d(0, '0, 0, '0, '0, '0);
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] wd;
      wd = {$urandom, $urandom};
      set_d(1, 64'h8000_0300, 1, wd, 8'h0F, 3'd2);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) set_i(1, 64'h8000_0010);
         mem_cmd_ready = (c == 3);
         @(negedge clk);
         n_checks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_payload_addr !== 64'h8000_0300 ||
                         mem_cmd_payload_wen !== 1'b1 || mem_cmd_payload_wstrb !== 8'h0F ||
                         mem_cmd_payload_wdata !== wd) begin n_fail++;
            $display("FAIL backpressure payload c%0d: got v=%b a=%h we=%b st=%h wd=%h", c,
                     mem_cmd_valid, mem_cmd_payload_addr, mem_cmd_payload_wen,
                     mem_cmd_payload_wstrb, mem_cmd_payload_wdata); end
         n_checks++; if (dcache_cmd_ready !== (c == 3) || icache_cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL backpressure ready c%0d: got dr=%b ir=%b want %b 0", c,
                               dcache_cmd_ready, icache_cmd_ready, c == 3); end
         tick();
      end
      set_d(0, '0, 0, '0, '0, '0); mem_rsp_valid = 1; mem_rsp_payload_data = '0;
      @(negedge clk);
      n_checks++; if (dcache_rsp_valid !== 1'b1 || icache_rsp_valid !== 1'b0) begin n_fail++;
         $display("FAIL backpressure write_ack: got d=%b i=%b want 1 0", dcache_rsp_valid,
                  icache_rsp_valid); end
      tick();
      mem_rsp_valid = 0; m_last_d = 1;
      @(negedge clk);
      n_checks++; if (icache_cmd_ready !== 1'b1 || mem_cmd_payload_addr !== 64'h8000_0010) begin
         n_fail++; $display("FAIL backpressure next_grant: got ir=%b a=%h", icache_cmd_ready,
                            mem_cmd_payload_addr); end
      tick();
      set_i(0, '0); mem_rsp_valid = 1; mem_rsp_payload_data = 64'h9999_8888_7777_6666;
      @(negedge clk);
      n_checks++; if (icache_rsp_payload_data !== 32'h7777_6666) begin n_fail++;
         $display("FAIL backpressure irsp: got %h want 77776666", icache_rsp_payload_data); end
      tick();
      mem_rsp_valid = 0; mem_cmd_ready = 0; m_last_d = 0;
   endtask

   task automatic test_reset_midop();
      set_d(1, 64'h8000_0200, 0, '0, '0, 3'd3); mem_cmd_ready = 1;
      tick();
      set_d(0, '0, 0, '0, '0, '0); mem_cmd_ready = 0; reset = 1;
      tick();
      reset = 0; mem_rsp_valid = 1; mem_rsp_payload_data = 64'h5555_5555_5555_5555;
      @(negedge clk);
      n_checks++; if (stray_rsp !== 1'b1) begin n_fail++;
         $display("FAIL reset_midop stray: got %b want 1", stray_rsp); end
      n_checks++; if (dcache_rsp_valid !== 1'b0 || icache_rsp_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_midop forwarded: got d=%b i=%b want 0 0", dcache_rsp_valid,
                  icache_rsp_valid); end
      tick();
      mem_rsp_valid = 0; m_last_d = 0;
      @(negedge clk);
      n_checks++; if (stray_rsp !== 1'b0) begin n_fail++;
         $display("FAIL reset_midop stray_pulse: got %b want 0", stray_rsp); end
      tick();
   endtask

   task automatic test_random(int n);
      bit ip, dp, dwe, win;
      logic [ADDR_W-1:0] ia, da;
      logic [DATA_W-1:0] dwd, rd;
      logic [7:0] dst;
      logic [2:0] dsz;
      int stall, rdly;
      ip = 0; dp = 0; ia = '0; da = '0; dwe = 0; dwd = '0; dst = '0; dsz = '0;
      for (int t = 0; t < n; t++) begin
         if (!ip && $urandom_range(1, 0) == 1) begin ip = 1; ia = {$urandom, $urandom}; end
         if (!dp && (!ip || $urandom_range(1, 0) == 1)) begin
            dp = 1; da = {$urandom, $urandom}; dwe = 1'($urandom_range(1, 0));
            dwd = {$urandom, $urandom}; dst = 8'($urandom); dsz = 3'($urandom_range(3, 0));
         end
         set_i(ip, ia); set_d(dp, da, dwe, dwd, dst, dsz);
         win = pick(ip, dp);
         stall = int'($urandom_range(3, 0));
         for (int c = 0; c <= stall; c++) begin
            mem_cmd_ready = (c == stall);
            @(negedge clk);
            n_checks++;
            if (win ? (mem_cmd_payload_addr !== da || mem_cmd_payload_wen !== dwe ||
                       mem_cmd_payload_wdata !== dwd || mem_cmd_payload_wstrb !== dst ||
                       mem_cmd_payload_size !== dsz)
                    : (mem_cmd_payload_addr !== ia || mem_cmd_payload_wen !== 1'b0 ||
                       mem_cmd_payload_wdata !== '0 || mem_cmd_payload_wstrb !== '0 ||
                       mem_cmd_payload_size !== 3'd2) || mem_cmd_valid !== 1'b1) begin
               n_fail++; $display("FAIL random cmd t%0d c%0d: got v=%b a=%h we=%b want dcache=%b",
                                  t, c, mem_cmd_valid, mem_cmd_payload_addr, mem_cmd_payload_wen,
                                  win); end
            n_checks++; if (dcache_cmd_ready !== (win && c == stall) ||
                            icache_cmd_ready !== (!win && c == stall)) begin n_fail++;
               $display("FAIL random ready t%0d c%0d: got dr=%b ir=%b want dcache=%b last=%b",
                        t, c, dcache_cmd_ready, icache_cmd_ready, win, c == stall); end
            tick();
         end
         if (win) dp = 0; else ip = 0;
         set_i(ip, ia); set_d(dp, da, dwe, dwd, dst, dsz);
         mem_cmd_ready = 1'($urandom_range(1, 0));
         rdly = int'($urandom_range(2, 0));
         rd = {$urandom, $urandom};
         for (int c = 0; c <= rdly; c++) begin
            mem_rsp_valid = (c == rdly); mem_rsp_payload_data = rd;
            @(negedge clk);
            n_checks++; if (mem_cmd_valid !== 1'b0 || icache_cmd_ready !== 1'b0 ||
                            dcache_cmd_ready !== 1'b0) begin n_fail++;
               $display("FAIL random busy t%0d c%0d: got v=%b ir=%b dr=%b want 0 0 0", t, c,
                        mem_cmd_valid, icache_cmd_ready, dcache_cmd_ready); end
            n_checks++; if (dcache_rsp_valid !== (win && c == rdly) ||
                            icache_rsp_valid !== (!win && c == rdly)) begin n_fail++;
               $display("FAIL random rsp_valid t%0d c%0d: got d=%b i=%b want dcache=%b", t, c,
                        dcache_rsp_valid, icache_rsp_valid, win); end
            if (c == rdly) begin
               n_checks++;
               if (win ? (!dwe && dcache_rsp_payload_data !== rd)
                       : (icache_rsp_payload_data !== (ia[2] ? rd[63:32] : rd[31:0]))) begin
                  n_fail++; $display("FAIL random rsp_data t%0d: got i=%h d=%h from %h", t,
                                     icache_rsp_payload_data, dcache_rsp_payload_data, rd); end
            end
            tick();
         end
         mem_rsp_valid = 0; mem_cmd_ready = 0; m_last_d = win;
      end
      set_i(0, '0); set_d(0, '0, 0, '0, '0, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_icache_only();
      test_priority();
      test_both_valid();
      test_backpressure();
      test_reset_midop();
      test_low_half();
      test_random(200);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
